// File: rtl/nochange_stim_pkg.sv
// Shared types for the $nochange stimulus generator: pattern modes and FSM states.
package nochange_stim_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        NONE   = 2'd0,
        EDGE   = 2'd1,
        IN_WIN = 2'd2,
        AFTER  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEAD = 3'd1,
        HIGH = 3'd2,
        TAIL = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/nochange_stim_gen_if.sv
// Request/pattern bundle of the $nochange stimulus generator.
// Self-check ports exist only when NOCHANGE_STIM_SELFCHECK_EN is defined.
interface nochange_stim_gen_if
    import nochange_stim_pkg::*;
#(
    parameter int CNT_W = 8
);

    logic             start;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] data_off;
    mode_e            mode;
    logic             ref_o;
    logic             data_o;
    logic             busy;
    logic             done;
    logic             expect_viol;
`ifdef NOCHANGE_STIM_SELFCHECK_EN
    logic             viol_seen;
    logic             mismatch;

    modport master (
        output start, high_len, data_off, mode,
        input  ref_o, data_o, busy, done, expect_viol, viol_seen, mismatch
    );
    modport slave (
        input  start, high_len, data_off, mode,
        output ref_o, data_o, busy, done, expect_viol, viol_seen, mismatch
    );
`else
    modport master (
        output start, high_len, data_off, mode,
        input  ref_o, data_o, busy, done, expect_viol
    );
    modport slave (
        input  start, high_len, data_off, mode,
        output ref_o, data_o, busy, done, expect_viol
    );
`endif

endinterface

// File: rtl/nochange_stim_gen_mon.sv
// Self-check monitor: flags a data change while ref is held high (rise cycle excluded)
// and keeps a sticky mismatch against the predicted violation flag.
module nochange_mon (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic ref_o,
    input  logic data_o,
    input  logic done,
    input  logic expect_viol,
    output logic viol_seen,
    output logic mismatch
);

    logic ref_p;
    logic data_p;
    logic hit_q;
    logic mismatch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_p      <= 1'b0;
            data_p     <= 1'b0;
            hit_q      <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            ref_p  <= ref_o;
            data_p <= data_o;
            if (clr)
                hit_q <= 1'b0;
            else if (ref_o && ref_p && (data_o != data_p))
                hit_q <= 1'b1;
            if (done && (hit_q != expect_viol))
                mismatch_q <= 1'b1;
        end
    end

    assign viol_seen = done & hit_q;
    assign mismatch  = mismatch_q;

endmodule

// File: rtl/nochange_stim_gen.sv
// Stimulus generator for $nochange(posedge ref, data, 0, 0): one ref-high window per run,
// at most one data toggle, and a predicted violation flag. Optional NOCHANGE_STIM_SELFCHECK_EN.
//
// state | meaning
// IDLE  | waiting for start, inputs latched on accept
// LEAD  | one cycle with ref low before the window
// HIGH  | ref high for L cycles, counter 0..L-1
// TAIL  | ref low again, last cycle before done
// DONE  | done pulse, start ignored
module nochange_stim_gen
    import nochange_stim_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    nochange_stim_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] off_q, off_d;
    mode_e            mode_q, mode_d;
    logic             viol_q, viol_d;
    logic             ref_q, ref_d;
    logic             data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ev_q, ev_d;

    logic [CNT_W-1:0] len_in;
    logic [CNT_W-1:0] cnt_inc;

    assign len_in  = (bus.high_len == '0) ? ONE : bus.high_len;
    assign cnt_inc = cnt_q + ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= ONE;
            off_q   <= '0;
            mode_q  <= NONE;
            viol_q  <= 1'b0;
            ref_q   <= 1'b0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ev_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            off_q   <= off_d;
            mode_q  <= mode_d;
            viol_q  <= viol_d;
            ref_q   <= ref_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ev_q    <= ev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        off_d   = off_q;
        mode_d  = mode_q;
        viol_d  = viol_q;
        ref_d   = ref_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ev_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LEAD;
                    busy_d  = 1'b1;
                    len_d   = len_in;
                    off_d   = bus.data_off;
                    mode_d  = bus.mode;
                    viol_d  = (bus.mode == IN_WIN) && (bus.data_off != '0) &&
                              (bus.data_off < len_in);
                end
            end
            LEAD: begin
                state_d = HIGH;
                ref_d   = 1'b1;
                cnt_d   = '0;
                // data_off=0 lands on the rise edge: simultaneous, not a violation
                if (mode_q == EDGE || (mode_q == IN_WIN && off_q == '0))
                    data_d = ~data_q;
            end
            HIGH: begin
                if (cnt_q == len_q - ONE) begin
                    state_d = TAIL;
                    ref_d   = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    if (mode_q == IN_WIN && off_q == cnt_inc)
                        data_d = ~data_q;
                end
            end
            TAIL: begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                ev_d    = viol_q;
                if (mode_q == AFTER)
                    data_d = ~data_q;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ref_o       = ref_q;
    assign bus.data_o      = data_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.expect_viol = ev_q;

`ifdef NOCHANGE_STIM_SELFCHECK_EN
    logic accept;
    assign accept = (state_q == IDLE) && bus.start;

    nochange_mon u_mon (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (accept),
        .ref_o       (ref_q),
        .data_o      (data_q),
        .done        (done_q),
        .expect_viol (ev_q),
        .viol_seen   (bus.viol_seen),
        .mismatch    (bus.mismatch)
    );
`endif

endmodule

// File: tb/tb_nochange_stim_gen.sv
// Randomized self-checking bench for nochange_stim_gen against a per-run waveform model.
module tb_nochange_stim_gen;
    import nochange_stim_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nochange_stim_gen_if #(.CNT_W(8)) bus ();

    nochange_stim_gen #(.CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    bit d_model = 1'b0;

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_ref"},  32'(bus.ref_o), 32'(0));
        check_val({tag, "_data"}, 32'(bus.data_o), 32'(0));
        check_val({tag, "_busy"}, 32'(bus.busy), 32'(0));
        check_val({tag, "_done"}, 32'(bus.done), 32'(0));
        check_val({tag, "_ev"},   32'(bus.expect_viol), 32'(0));
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after E(L+3).
    task automatic run_pattern(input int hl, input int off, input int md, input bit noise);
        int  len, tog, dc0;
        bit  ev, d0, d_exp;
        len = (hl == 0) ? 1 : hl;
        tog = -1;
        if (md == 1) tog = 1;
        else if (md == 2 && off < len) tog = 1 + off;
        else if (md == 3) tog = len + 2;
        ev  = (md == 2) && (off >= 1) && (off < len);
        d0  = d_model;
        dc0 = done_cnt;
        bus.start    = 1'b1;
        bus.high_len = 8'(hl);
        bus.data_off = 8'(off);
        bus.mode     = mode_e'(md[1:0]);
        for (int k = 0; k <= len + 3; k++) begin
            @(negedge clk);
            d_exp = d0 ^ ((tog >= 0) && (k >= tog));
            check_val($sformatf("ref_k%0d", k),  32'(bus.ref_o),  32'((k >= 1) && (k <= len)));
            check_val($sformatf("busy_k%0d", k), 32'(bus.busy),   32'(k <= len + 1));
            check_val($sformatf("done_k%0d", k), 32'(bus.done),   32'(k == len + 2));
            check_val($sformatf("data_k%0d", k), 32'(bus.data_o), 32'(d_exp));
            if (k == len + 2) begin
                check_val("expect_viol", 32'(bus.expect_viol), 32'(ev));
`ifdef NOCHANGE_STIM_SELFCHECK_EN
                check_val("viol_seen", 32'(bus.viol_seen), 32'(ev));
`endif
            end
            // Later input activity, including start while busy or in DONE, must be ignored.
            bus.start = (noise && k < len + 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                bus.high_len = 8'($urandom_range(0, 255));
                bus.data_off = 8'($urandom_range(0, 255));
                bus.mode     = mode_e'(2'($urandom_range(0, 3)));
            end
        end
        check_val("done_count", 32'(done_cnt - dc0), 32'(1));
        d_model = d0 ^ (tog >= 0);
    endtask

    initial begin
        int dc0;
        bus.start    = 1'b0;
        bus.high_len = '0;
        bus.data_off = '0;
        bus.mode     = NONE;

        #2;
        check_idle("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        run_pattern(4, 0, 0, 1'b0);
        run_pattern(3, 0, 1, 1'b0);
        run_pattern(5, 2, 2, 1'b0);
        run_pattern(3, 7, 2, 1'b0);
        run_pattern(0, 0, 0, 1'b0);
        run_pattern(2, 0, 3, 1'b1);
        run_pattern(3, 0, 2, 1'b0);
        run_pattern(4, 3, 2, 1'b0);
        run_pattern(4, 4, 2, 1'b1);
        run_pattern(0, 1, 2, 1'b0);
        run_pattern(255, 254, 2, 1'b0);

        // Reset at E4 of an IN_WIN run with L=8.
        bus.start    = 1'b1;
        bus.high_len = 8'd8;
        bus.data_off = 8'd3;
        bus.mode     = IN_WIN;
        @(posedge clk);
        #1 bus.start = 1'b0;
        dc0 = done_cnt;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_idle("midrun_reset");
        d_model = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_val("no_done_after_reset", 32'(done_cnt - dc0), 32'(0));
        check_idle("after_reset_idle");
        run_pattern(6, 2, 2, 1'b0);

        for (int r = 0; r < 40; r++)
            run_pattern(int'($urandom_range(0, 12)), int'($urandom_range(0, 14)),
                        int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

`ifdef NOCHANGE_STIM_SELFCHECK_EN
        check_val("mismatch_sticky", 32'(bus.mismatch), 32'(0));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nochange_stim_gen.md
Name: nochange_stim_gen

Overview:
- Synthesizable stimulus generator for the $nochange timing-check tests. It drives the reference signal and the data signal that a $nochange(posedge ref, data, 0, 0) check consumes.
- Each run produces one reference-high window and places at most one data transition at a programmed position relative to that window.
- With each run it reports whether the pattern must produce a violation. Benches can therefore provoke legal, simultaneous-edge and illegal cases deterministically.

Parameters:
- CNT_W, 8, width of the window-length and offset fields.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to run one pattern; ignored while busy=1.
- high_len  input  CNT_W  reference-high length in cycles; 0 is treated as 1.
- data_off  input  CNT_W  data toggle offset (cycles after the reference rise) for mode IN_WIN.
- mode  input  2  0 NONE, 1 EDGE, 2 IN_WIN, 3 AFTER.
- ref_o  output  1  reference signal, the "clk" of the check.
- data_o  output  1  data signal, the "data" of the check.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at the end of a run.
- expect_viol  output  1  valid only while done=1; 1 means the pattern contains a violation.

Behaviour:
- Reset (async, rst_n=0): ref_o=0, data_o=0, busy=0, done=0, expect_viol=0, state IDLE, counter=0. All outputs are registered.
- start, high_len, data_off and mode are latched on the edge that accepts start (edge E0). Later input changes do not affect the running pattern.
- Let L = max(high_len, 1).
- FSM states: IDLE, LEAD, HIGH, TAIL, DONE.
  - IDLE -> LEAD on start at E0; busy=1 after E0.
  - LEAD -> HIGH at E1; ref_o=1 after E1.
  - HIGH holds ref_o=1 after edges E1..EL, L cycles in total. The counter runs 0..L-1.
  - HIGH -> TAIL at E(L+1); ref_o=0 after E(L+1).
  - TAIL -> DONE at E(L+2); done=1 and busy=0 after E(L+2).
  - DONE -> IDLE at the next edge; done returns to 0.
  - Run latency from start to done is exactly L+2 edges.
- data_o toggles (inverts) at most once per run:
  - NONE: no toggle.
  - EDGE: toggles at E1, the same edge as the ref_o rise.
  - IN_WIN: toggles at E(1+data_off) only if data_off < L; otherwise no toggle.
  - AFTER: toggles at E(L+2), in the same cycle that done asserts.
- expect_viol is 1 iff mode=IN_WIN and 1 <= data_off < L.
  - data_off=0 is simultaneous with the rise, which is not a violation.
  - data_off >= L produces no toggle.
- data_o is not restored between runs. Its level carries over; only transitions matter.
- start asserted in DONE is ignored. The next run needs start with busy=0 and state IDLE.
- Reset mid-run returns to the reset values immediately. No done pulse is produced.

Optional Feature:
- NOCHANGE_STIM_SELFCHECK_EN defined:
  - Instantiates an internal monitor that flags a data_o change in any cycle where ref_o is high, excluding the rise cycle.
  - Adds output viol_seen (1 bit, valid with done).
  - Adds output mismatch, a sticky flag set when viol_seen != expect_viol at done. It is cleared only by reset.
- Undefined: neither port exists and no monitor logic is present.

Decomposition:
- Shared package nochange_stim_pkg holds:
  - mode_e enum: NONE, EDGE, IN_WIN, AFTER.
  - state_e enum.
  - MODE_W=2.
- Sub-module nochange_mon (the self-check monitor), instantiated only under NOCHANGE_STIM_SELFCHECK_EN.

Test Plan:
- mode=NONE, high_len=4 -> ref_o high for exactly 4 cycles; data_o constant; done 6 edges after start; expect_viol=0.
- mode=EDGE, high_len=3 -> data_o and ref_o change on the same edge E1; expect_viol=0; viol_seen=0 with self-check enabled.
- mode=IN_WIN, high_len=5, data_off=2 -> data_o toggles at E3 while ref_o=1; expect_viol=1; mismatch stays 0.
- mode=IN_WIN, high_len=3, data_off=7 -> no data toggle; expect_viol=0. Also high_len=0 -> ref_o high 1 cycle, done 3 edges after start.
- mode=AFTER, high_len=2 -> toggle coincides with done at E4; expect_viol=0. A start pulse during busy is ignored: exactly one done.
- Start IN_WIN with L=8 and drop rst_n at E4 -> all outputs 0 immediately, no done; a fresh start afterwards runs normally.
